// File: rtl/adder_seq_ctrl_if.sv
// rtl/adder_seq_ctrl_if.sv - request/result handshake bundle for adder_seq_ctrl
// op_sub exists only when ADDER_SEQ_SUB_EN is defined.
interface adder_seq_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_ci;
`ifdef ADDER_SEQ_SUB_EN
  logic             op_sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, op_a, op_b, op_ci,
`ifdef ADDER_SEQ_SUB_EN
    output op_sub,
`endif
    output out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, op_a, op_b, op_ci,
`ifdef ADDER_SEQ_SUB_EN
    input  op_sub,
`endif
    input  out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/adder_seq_ctrl.sv
// rtl/adder_seq_ctrl.sv - nibble-serial adder through one shared 4-bit CLA slice
// Optional subtract mode enabled by defining ADDER_SEQ_SUB_EN.
module adder_seq_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;
  logic       c3;

  assign g = a & b;
  assign p = a ^ b;

  // Flat lookahead terms: every carry depends only on g/p and ci.
  assign c1 = g[0] | (p[0] & ci);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & ci);
  assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s = p ^ {c3, c2, c1, ci};
endmodule

module adder_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input logic              clk,
  input logic              rst_n,
  adder_seq_ctrl_if.slave  bus
);
  localparam int N     = WIDTH / 4;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic [IDX_W-1:0] idx_q;

  logic             accept;
  logic             last_nib;
  logic             in_ready_c;
  logic             out_valid_c;
  logic             busy_c;
  logic             sub_sel;

  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       nib_s;
  logic             nib_co;

`ifdef ADDER_SEQ_SUB_EN
  assign sub_sel = bus.op_sub;
`else
  assign sub_sel = 1'b0;
`endif

  always_comb begin
    nib_a = 4'd0;
    nib_b = 4'd0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
  end

  // The only path from one nibble's carry to the next is carry_q.
  adder_seq_cla4 u_slice (
    .a  (nib_a),
    .b  (nib_b),
    .ci (carry_q),
    .s  (nib_s),
    .co (nib_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b0;
    accept      = 1'b0;
    last_nib    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy_c = 1'b1;
        if (idx_q == IDX_W'(N - 1)) begin
          last_nib = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        busy_c      = 1'b1;
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else if (accept) begin
      a_q     <= bus.op_a;
      b_q     <= sub_sel ? ~bus.op_b : bus.op_b;
      carry_q <= sub_sel ? 1'b1 : bus.op_ci;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      for (int i = 0; i < N; i++) begin
        if (idx_q == IDX_W'(i)) begin
          sum_q[4*i +: 4] <= nib_s;
        end
      end
      carry_q <= nib_co;
      if (last_nib) begin
        cout_q <= nib_co;
        idx_q  <= '0;
      end else begin
        idx_q  <= idx_q + IDX_W'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = busy_c;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb/tb_adder_seq_ctrl.sv - self-checking bench for adder_seq_ctrl (WIDTH=16)
module tb_adder_seq_ctrl;
  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 4;

  logic clk;
  logic rst_n;
  logic sub_drv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  adder_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

`ifdef ADDER_SEQ_SUB_EN
  assign bus.op_sub = sub_drv;
`endif

  adder_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the whole word.
  function automatic logic [WIDTH:0] ref_result(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic ci, input logic sub);
    logic [WIDTH-1:0] bb;
    logic             c;
    bb = sub ? ~b : b;
    c  = sub ? 1'b1 : ci;
    return {1'b0, a} + {1'b0, bb} + (WIDTH+1)'(c);
  endfunction

  // Transaction-level model: accept when idle, result visible N cycles later.
  logic             m_idle;
  logic             m_valid;
  int               m_cnt;
  logic [WIDTH-1:0] m_sum;
  logic             m_cout;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle  <= 1'b1;
      m_valid <= 1'b0;
      m_cnt   <= 0;
      m_sum   <= '0;
      m_cout  <= 1'b0;
    end else if (m_idle) begin
      if (bus.in_valid) begin
        m_idle <= 1'b0;
        m_cnt  <= N;
        {m_cout, m_sum} <= ref_result(bus.op_a, bus.op_b, bus.op_ci, sub_drv);
      end
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_valid <= 1'b1;
    end else if (m_valid && bus.out_ready) begin
      m_valid <= 1'b0;
      m_idle  <= 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("cyc_in_ready", 32'(bus.in_ready), 32'(m_idle));
    chk("cyc_out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("cyc_busy", 32'(bus.busy), 32'(!m_idle));
    if (m_valid) begin
      chk("cyc_sum", 32'(bus.sum), 32'(m_sum));
      chk("cyc_cout", 32'(bus.cout), 32'(m_cout));
    end
  end

  task automatic wait_valid(input string name, output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 50) chk({name, "_valid_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic ci, input logic sub,
                        input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
    int guard;
    int lat;
    bus.op_a = a;
    bus.op_b = b;
    bus.op_ci = ci;
    sub_drv = sub;
    bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) chk({name, "_accept_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_valid(name, lat);
    chk({name, "_latency"}, 32'(lat), 32'(N));
    chk({name, "_sum"}, 32'(bus.sum), 32'(exp_sum));
    chk({name, "_cout"}, 32'(bus.cout), 32'(exp_cout));
    chk({name, "_model_sum"}, 32'(m_sum), 32'(exp_sum));
    chk({name, "_model_cout"}, 32'(m_cout), 32'(exp_cout));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({name, "_back_idle"}, 32'(bus.in_ready), 32'd1);
    sub_drv = 1'b0;
  endtask

  initial begin
    int lat;
    rst_n = 1'b0;
    sub_drv = 1'b0;
    bus.in_valid = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.op_ci = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    run_op("add_00ff", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0);
    run_op("add_ffff", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    run_op("add_1234", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0);
    run_op("add_max",  16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1);

    // Result held in DONE while a new request waits.
    bus.op_a = 16'h1234; bus.op_b = 16'h4321; bus.op_ci = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_valid("hold", lat);
    bus.op_a = 16'h0001; bus.op_b = 16'h0001; bus.op_ci = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_sum", 32'(bus.sum), 32'h5556);
      chk("hold_cout", 32'(bus.cout), 32'd0);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("hold_not_taken", 32'(bus.in_ready), 32'd1);
    chk("hold_idle_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("hold_taken", 32'(bus.in_ready), 32'd0);
    chk("hold_taken_busy", 32'(bus.busy), 32'd1);
    wait_valid("hold2", lat);
    chk("hold2_latency", 32'(lat), 32'(N));
    chk("hold2_sum", 32'(bus.sum), 32'h0002);
    chk("hold2_cout", 32'(bus.cout), 32'd0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;

    // Reset during the second RUN cycle.
    bus.op_a = 16'h00FF; bus.op_b = 16'h0001; bus.op_ci = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_run_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_sum", 32'(bus.sum), 32'd0);
    chk("arst_cout", 32'(bus.cout), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_valid", 32'(bus.out_valid), 32'd0);
    end
    run_op("after_rst", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0);

`ifdef ADDER_SEQ_SUB_EN
    run_op("sub_5_7", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
    run_op("sub_7_5", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1);
`endif

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
